// File: rtl/stream_src_pkg.sv
// Shared types and helpers for the stream source controller.
package stream_src_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Ceiling log2, never below 1 so single-value ranges still get a bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/stream_edge_rise.sv
// Registered rising-edge detector: rise is high on the first clk where din is 1 after a 0.
module stream_edge_rise #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise
);

   logic [W-1:0] din_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) din_q <= '0;
      else      din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/stream_src_ctrl.sv
// Start/stop controller muxing N_CH free-running sources onto one buffer write port.
// Optional registered write parity via STREAM_SRC_PARITY_EN.
module stream_src_ctrl
   import stream_src_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 16,
   parameter int DRAIN_TO = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          start,
   input  logic                     stop,
   input  logic [N_CH-1:0]          src_valid,
   input  logic [N_CH*DATA_W-1:0]   src_data,
   input  logic                     buf_full,
   input  logic                     buf_empty,
   input  logic                     rd_valid,
   output logic [N_CH-1:0]          en,
   output logic [clog2(N_CH)-1:0]   active_ch,
   output logic                     wr_en,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     drain_err
`ifdef STREAM_SRC_PARITY_EN
  ,output logic                     wr_parity
`endif
);

   localparam int CH_W  = clog2(N_CH);
   localparam int CNT_W = clog2(DRAIN_TO);

   state_t            state;
   logic [CNT_W-1:0]  drain_cnt;
   logic [N_CH-1:0]   start_rise;
   logic              stop_rise;
   logic [CH_W-1:0]   first_ch;
   logic [DATA_W-1:0] ch_data [N_CH];
   logic              wr_go;

   stream_edge_rise #(.W(N_CH)) u_start_rise (
      .clk  (clk),
      .rst  (rst),
      .din  (start),
      .rise (start_rise)
   );

   stream_edge_rise #(.W(1)) u_stop_rise (
      .clk  (clk),
      .rst  (rst),
      .din  (stop),
      .rise (stop_rise)
   );

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign ch_data[i] = src_data[i*DATA_W +: DATA_W];
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      first_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (start_rise[i]) first_ch = CH_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         active_ch <= '0;
         drain_err <= 1'b0;
         drain_cnt <= '0;
      end else begin
         if (state != DRAIN) drain_cnt <= '0;
         case (state)
            IDLE: begin
               if (|start_rise) begin
                  state     <= RUN;
                  active_ch <= first_ch;
                  drain_err <= 1'b0;
               end
            end
            RUN: begin
               if (stop_rise)     state <= DRAIN;
               else if (buf_full) state <= WAIT;
            end
            WAIT: begin
               if (stop_rise)      state <= DRAIN;
               else if (!buf_full) state <= RUN;
            end
            DRAIN: begin
               if (buf_empty && !rd_valid) begin
                  state <= IDLE;
               end else if (drain_cnt == CNT_W'(DRAIN_TO - 1)) begin
                  state     <= IDLE;
                  drain_err <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Enable is a decode of registered state, so it tracks state with no extra latency.
   always_comb begin
      en = '0;
      if (state == RUN) en[active_ch] = 1'b1;
   end

   assign busy  = (state != IDLE);
   assign wr_go = (state == RUN) && src_valid[active_ch] && !buf_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_data <= '0;
`ifdef STREAM_SRC_PARITY_EN
         wr_parity <= 1'b0;
`endif
      end else begin
         wr_en <= wr_go;
         if (wr_go) begin
            wr_data <= ch_data[active_ch];
`ifdef STREAM_SRC_PARITY_EN
            wr_parity <= ^ch_data[active_ch];
`endif
         end
      end
   end

endmodule

// File: tb/tb_stream_src_ctrl.sv
// Scoreboard bench for stream_src_ctrl: expected writes are queued, a negedge monitor pops them.
module tb_stream_src_ctrl;

   localparam int N_CH     = 4;
   localparam int DATA_W   = 16;
   localparam int DRAIN_TO = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_CH-1:0]        start;
   logic                   stop;
   logic [N_CH-1:0]        src_valid;
   logic [N_CH*DATA_W-1:0] src_data;
   logic                   buf_full;
   logic                   buf_empty;
   logic                   rd_valid;
   logic [N_CH-1:0]        en;
   logic [1:0]             active_ch;
   logic                   wr_en;
   logic [DATA_W-1:0]      wr_data;
   logic                   busy;
   logic                   drain_err;
`ifdef STREAM_SRC_PARITY_EN
   logic                   wr_parity;
`endif

   int                vectors = 0;
   int                errors  = 0;
   logic [DATA_W-1:0] sb_q [$];
   logic [DATA_W-1:0] exp_d;

   stream_src_ctrl #(
      .N_CH     (N_CH),
      .DATA_W   (DATA_W),
      .DRAIN_TO (DRAIN_TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .src_valid (src_valid),
      .src_data  (src_data),
      .buf_full  (buf_full),
      .buf_empty (buf_empty),
      .rd_valid  (rd_valid),
      .en        (en),
      .active_ch (active_ch),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .busy      (busy),
      .drain_err (drain_err)
`ifdef STREAM_SRC_PARITY_EN
     ,.wr_parity (wr_parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int ch, input logic [DATA_W-1:0] d);
      src_valid[ch]                = 1'b1;
      src_data[ch*DATA_W +: DATA_W] = d;
   endtask

   task automatic sb_drained();
      @(negedge clk);
      #1;
      check("sb_drained", sb_q.size(), 0);
   endtask

   // Monitor: every write strobe must match the oldest expected word.
   always @(negedge clk) begin
      if (wr_en) begin
         vectors++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got %h expected no write", wr_data);
         end else begin
            exp_d = sb_q.pop_front();
            if (wr_data !== exp_d) begin
               errors++;
               $display("FAIL wr_data: got %h expected %h", wr_data, exp_d);
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      start     = '0;
      stop      = 1'b0;
      src_valid = '0;
      src_data  = '0;
      buf_full  = 1'b0;
      buf_empty = 1'b0;
      rd_valid  = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("rst_en",        en,        4'b0000);
      check("rst_active_ch", active_ch, 2'd0);
      check("rst_wr_en",     wr_en,     1'b0);
      check("rst_wr_data",   wr_data,   16'h0000);
      check("rst_busy",      busy,      1'b0);
      check("rst_drain_err", drain_err, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Start on channel 2, one write with a concurrent beat from idle channel 1
      start = 4'b0100;
      step();
      check("start_en",        en,        4'b0100);
      check("start_active_ch", active_ch, 2'd2);
      check("start_busy",      busy,      1'b1);
      start = '0;
      set_src(2, 16'h00A5);
      set_src(1, 16'h1111);
      sb_q.push_back(16'h00A5);
      step();
      check("first_wr_en",   wr_en,   1'b1);
      check("first_wr_data", wr_data, 16'h00A5);
      src_valid = '0;
      sb_drained();

      // Pause on buf_full, beats dropped, then resume
      buf_full = 1'b1;
      step();
      check("wait_en",   en,   4'b0000);
      check("wait_busy", busy, 1'b1);
      set_src(2, 16'hBEEF);
      step();
      step();
      check("wait_no_wr", wr_en, 1'b0);
      buf_full  = 1'b0;
      src_valid = '0;
      step();
      check("resume_en", en, 4'b0100);
      set_src(2, 16'h1234);
      sb_q.push_back(16'h1234);
      step();
      src_valid = '0;
      sb_drained();

      // Stop together with buf_full: stop wins, then drain completes normally
      buf_full = 1'b1;
      stop     = 1'b1;
      step();
      check("drain_en",   en,   4'b0000);
      check("drain_busy", busy, 1'b1);
      buf_full = 1'b0;
      stop     = 1'b0;
      step();
      step();
      check("drain_not_run", en,   4'b0000);
      check("drain_hold",    busy, 1'b1);
      buf_empty = 1'b1;
      rd_valid  = 1'b1;
      step();
      check("drain_rd_valid", busy, 1'b1);
      rd_valid = 1'b0;
      step();
      check("idle_busy",      busy,      1'b0);
      check("idle_drain_err", drain_err, 1'b0);
      check("idle_en",        en,        4'b0000);
      check("idle_active_ch", active_ch, 2'd2);
      stop = 1'b1;
      step();
      check("idle_stop_ignored", busy, 1'b0);
      stop      = 1'b0;
      buf_empty = 1'b0;
      step();

      // Drain timeout: exactly DRAIN_TO cycles in DRAIN, then sticky drain_err
      start = 4'b0001;
      step();
      check("t_active_ch", active_ch, 2'd0);
      check("t_en",        en,        4'b0001);
      start = '0;
      stop  = 1'b1;
      step();
      check("t_drain_entry", busy, 1'b1);
      for (int i = 1; i < DRAIN_TO; i++) begin
         step();
         check("t_drain_busy", busy, 1'b1);
      end
      step();
      check("t_timeout_busy", busy,      1'b0);
      check("t_timeout_err",  drain_err, 1'b1);
      stop = 1'b0;
      repeat (4) step();
      check("t_err_sticky", drain_err, 1'b1);
      check("t_stays_idle", busy,      1'b0);

      // Simultaneous starts pick the lowest index; later rises are ignored
      start = 4'b1010;
      step();
      check("multi_active_ch", active_ch, 2'd1);
      check("multi_en",        en,        4'b0010);
      check("multi_err_clr",   drain_err, 1'b0);
      start = 4'b1011;
      step();
      check("late_start_ch", active_ch, 2'd1);
      check("late_start_en", en,        4'b0010);
      start = '0;

      // Asynchronous reset mid-write
      set_src(1, 16'h0007);
      sb_q.push_back(16'h0007);
      step();
      src_valid = '0;
      check("pre_rst_wr_en",   wr_en,   1'b1);
      check("pre_rst_wr_data", wr_data, 16'h0007);
`ifdef STREAM_SRC_PARITY_EN
      check("wr_parity", wr_parity, 1'b1);
`endif
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_en",        en,        4'b0000);
      check("arst_wr_en",     wr_en,     1'b0);
      check("arst_busy",      busy,      1'b0);
      check("arst_active_ch", active_ch, 2'd0);
      check("arst_wr_data",   wr_data,   16'h0000);
      #1 rst = 1'b1;
      step();
      step();
      check("post_rst_busy", busy, 1'b0);
      check("sb_final", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
